seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU. Sits inside the execute stage, alongside the ALU.
//  Captures rs/rt operands from the ID/EX boundary and produces {HI=remainder, LO=quotient}.
//  Results feed the DivHiE/DivLoE path into the memory stage.
//  busy drives the hazard unit, which stalls F/D and flushes E while a divide is in flight.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be >= 2
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      asynchronous active-low reset
//  flush         in   1      abort in-flight divide (FlushE); sync, highest priority after reset
//  start         in   1      launch divide; sampled only in IDLE
//  is_signed     in   1      1 = DIV (two's complement), 0 = DIVU
//  dividend      in   WIDTH  rs value
//  divisor       in   WIDTH  rt value
//  busy          out  1      high from the cycle after an accepted start until done
//  done          out  1      one-cycle pulse; quotient/remainder valid this cycle and held after
//  quotient      out  WIDTH  LO result
//  remainder     out  WIDTH  HI result
//  div_by_zero   out  1      set with done when divisor==0; held until next start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, count=0.
//  States (encoding):
//   IDLE(0) -> CALC on start; captures magnitudes |dividend| and |divisor|,
//    plus neg_q = sign(a)^sign(b) and neg_r = sign(a) when is_signed.
//   CALC(1): one shift/subtract per cycle for WIDTH cycles (count WIDTH-1..0).
//    Each cycle: rem = {rem,q_msb}; if rem >= d then rem -= d and q bit = 1.
//   FIX(2): applies sign fixup (negate q if neg_q, negate r if neg_r) and registers the outputs.
//   DONE(3): done=1 for exactly one cycle, then -> IDLE.
//  Latency: start sampled at edge N -> done high in cycle N+WIDTH+2 (34 for WIDTH=32).
//  Divisor==0: IDLE -> FIX directly. Outputs quotient = all-ones, remainder = dividend (raw),
//   div_by_zero=1. Latency 2 cycles.
//  Signed overflow (-2^(W-1) / -1): quotient = 0x80000000, remainder = 0; no flag.
//   Falls out of unsigned magnitude math.
//  Remainder takes the dividend's sign (MIPS/C truncation semantics).
//  start while busy: ignored; no queuing.
//  start asserted in the DONE cycle: ignored; a new start is accepted next cycle, from IDLE.
//  flush: any state -> IDLE next edge; busy=0, done suppressed, outputs keep their last values.
//  flush and start in the same cycle: flush wins; nothing is launched.
//  reset_n low mid-operation: immediate return to reset values; no partial result is visible.
//  Operands are captured at start; later changes on dividend/divisor have no effect.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   In IDLE, if |dividend| < |divisor| (and divisor != 0), skip CALC and go straight to FIX.
//   Result: q = 0, r = dividend. Latency 2 cycles.
//  DIV_EARLY_OUT_EN undefined: every nonzero-divisor divide takes the full WIDTH+2 cycles.
//   Results are bit-identical either way.
// STRUCTURE
//  div_defs.vh (shared include, guarded):
//   state localparams DIV_IDLE/DIV_CALC/DIV_FIX/DIV_DONE
//   DIV_STATE_W = 2
//   DIV_ZERO_Q  = all-ones pattern
//  Sub-module div_step (combinational):
//   inputs  partial remainder, next dividend bit, divisor
//   outputs next remainder, quotient bit
//   one instance, reused every CALC cycle.
//  Counter width is $clog2(WIDTH).
// TESTING
//  1. DIVU 100/7, start 1 cycle -> done at +34: quotient=14, remainder=2, busy high 33 cycles.
//  2. DIV -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
//     DIV 7/-2 -> quotient=-3, remainder=1.
//  3. DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
//  4. DIVU 5/0 -> done at +2: quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
//  5. start DIVU 1000/3, flush at cycle +10:
//     -> busy=0 next cycle, no done pulse; a second start of 9/3 then yields q=3, r=0.
//  6. reset_n pulsed low at cycle +5 of a divide -> all outputs 0 immediately, state IDLE.
//     With DIV_EARLY_OUT_EN: DIVU 3/10 -> done at +2, q=0, r=3.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding for the sequential divider
// Purpose: FSM state type and width used by seq_divider.
// Ports: none (package).
package seq_divider_pkg;

  localparam int DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring shift/subtract step
// Purpose: combinational radix-2 restoring step, reused every CALC cycle.
// Ports:
//   rem_in   in   WIDTH  partial remainder
//   bit_in   in   1      next dividend bit shifted into the remainder
//   divisor  in   WIDTH  divisor magnitude
//   rem_out  out  WIDTH  next partial remainder
//   q_bit    out  1      quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // One extra bit: the shifted remainder can exceed WIDTH bits before subtraction.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring DIV/DIVU unit
// Purpose: captures operands on start, iterates WIDTH restoring steps, applies
//   sign fixup and presents {remainder, quotient} with a one-cycle done pulse.
// Optional feature macro: DIV_EARLY_OUT_EN (skip CALC when |dividend| < |divisor|).
// Ports:
//   clock        in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset
//   flush        in   1      abort in-flight divide, highest sync priority
//   start        in   1      launch divide, sampled only in IDLE
//   is_signed    in   1      1 = two's complement, 0 = unsigned
//   dividend     in   WIDTH  rs value
//   divisor      in   WIDTH  rt value
//   busy         out  1      divide in flight (CALC/FIX)
//   done         out  1      one-cycle result pulse
//   quotient     out  WIDTH  LO result
//   remainder    out  WIDTH  HI result
//   div_by_zero  out  1      divisor was zero, held until next start
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV_ZERO_Q = '1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
  logic [WIDTH-1:0] work_q, work_d;     // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;     // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             early_out;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (work_q[WIDTH-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    work_d        = work_q;
    dvsr_d        = dvsr_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    if (flush) begin
      // Abort: only the state moves; results from the previous divide stay visible.
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            div_by_zero_d = 1'b0;
            if (divisor == '0) begin
              // Pre-load the final answer; FIX passes it through without sign fixup.
              state_d = DIV_FIX;
              dz_d    = 1'b1;
              rem_d   = dividend;
              work_d  = DIV_ZERO_Q;
              q_neg_d = 1'b0;
              r_neg_d = 1'b0;
            end else if (early_out) begin
              state_d = DIV_FIX;
              dz_d    = 1'b0;
              rem_d   = dividend;
              work_d  = '0;
              q_neg_d = 1'b0;
              r_neg_d = 1'b0;
            end else begin
              state_d = DIV_CALC;
              count_d = CNT_LAST;
              dz_d    = 1'b0;
              rem_d   = '0;
              work_d  = a_mag;
              dvsr_d  = b_mag;
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = a_neg;
            end
          end
        end
        DIV_CALC: begin
          rem_d  = step_rem;
          work_d = {work_q[WIDTH-2:0], step_q_bit};
          if (count_q == '0) begin
            state_d = DIV_FIX;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        DIV_FIX: begin
          quotient_d    = q_neg_q ? -work_q : work_q;
          remainder_d   = r_neg_q ? -rem_q : rem_q;
          div_by_zero_d = dz_q;
          state_d       = DIV_DONE;
        end
        DIV_DONE: begin
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DIV_IDLE;
      count_q       <= '0;
      rem_q         <= '0;
      work_q        <= '0;
      dvsr_q        <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      work_q        <= work_d;
      dvsr_q        <= dvsr_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q == DIV_CALC) || (state_q == DIV_FIX);
  assign done        = (state_q == DIV_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
